// File: rtl/calcu_b_if.sv
// RAM-side bus of the b-coefficient stage: ena/done handshake plus the
// A/M read ports and the B write port. master = stage, slave = RAMs/control.
interface calcu_b_if #(
  parameter int AW = 17,
  parameter int DW = 24
);
  logic          ena;
  logic          done;
  logic [DW-1:0] oDataA;
  logic [DW-1:0] oDataM;
  logic [AW-1:0] iAddrA;
  logic [AW-1:0] iAddrM;
  logic          wrenA;
  logic          wrenM;
  logic [AW-1:0] iAddrB;
  logic          wrenB;
  logic [DW-1:0] iDataB;

  modport master (
    input  ena, oDataA, oDataM,
    output done, iAddrA, iAddrM, wrenA, wrenM,
    output iAddrB, wrenB, iDataB
  );

  modport slave (
    output ena, oDataA, oDataM,
    input  done, iAddrA, iAddrM, wrenA, wrenM,
    input  iAddrB, wrenB, iDataB
  );
endinterface

// File: rtl/calcu_b.sv
// Guided-filter b stage: b = ((128 - min(a,128)) * mean_I) >> FRAC per pixel.
// Ports: iCLK, iRST_N (sync, active-low), bus (calcu_b_if.master).
module calcu_b #(
  parameter int NPIX   = 120000,
  parameter int AW     = 17,
  parameter int DW     = 24,
  parameter int FRAC   = 7,
  parameter int RD_LAT = 1
) (
  input  logic      iCLK,
  input  logic      iRST_N,
  calcu_b_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);
  localparam logic [7:0]    DRN  = 8'(RD_LAT);
  localparam int            PW   = DW + FRAC + 1;
  localparam logic [DW-1:0] ONE  = DW'(1 << FRAC);

  state_t        state, state_n;
  logic [AW-1:0] rd_addr, rd_addr_n;
  logic [7:0]    cnt, cnt_n;
  logic          done_c;
  logic [AW-1:0] addr_c;

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state   <= IDLE;
      rd_addr <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      rd_addr <= rd_addr_n;
      cnt     <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    rd_addr_n = rd_addr;
    cnt_n     = cnt;
    done_c    = 1'b0;
    addr_c    = '0;
    unique case (state)
      IDLE: begin
        rd_addr_n = '0;
        if (bus.ena) state_n = RUN;
      end
      RUN: begin
        addr_c = rd_addr;
        if (rd_addr == LAST) begin
          rd_addr_n = '0;
          cnt_n     = DRN;
          state_n   = DRAIN;
        end else begin
          rd_addr_n = rd_addr + 1'b1;
        end
      end
      // RD_LAT+1 cycles: lets the last read return and its b register
      DRAIN: begin
        if (cnt == '0) state_n = DONE;
        else           cnt_n   = cnt - 1'b1;
      end
      DONE: begin
        done_c  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.iAddrA = addr_c;
  assign bus.iAddrM = addr_c;
  assign bus.wrenA  = 1'b0;
  assign bus.wrenM  = 1'b0;
  assign bus.done   = done_c;

  logic [FRAC:0] a_c;
  logic [FRAC:0] one_m;
  logic [PW-1:0] prod;
  logic [DW-1:0] b;

  // a above 1.0 saturates so (1 - a) never goes negative
  always_comb begin
    a_c   = (bus.oDataA > ONE) ? ONE[FRAC:0] : bus.oDataA[FRAC:0];
    one_m = ONE[FRAC:0] - a_c;
    prod  = PW'(one_m) * PW'(bus.oDataM);
    b     = DW'(prod >> FRAC);
  end

  // vld/adr follow each read until its data returns; the
  // output register is the final stage
  logic [RD_LAT-1:0] vld;
  logic [AW-1:0]     adr [RD_LAT];

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      vld        <= '0;
      for (int i = 0; i < RD_LAT; i++) adr[i] <= '0;
      bus.wrenB  <= 1'b0;
      bus.iAddrB <= '0;
      bus.iDataB <= '0;
    end else begin
      vld[0] <= (state == RUN);
      adr[0] <= rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        adr[i] <= adr[i-1];
      end
      bus.wrenB  <= vld[RD_LAT-1];
      bus.iAddrB <= vld[RD_LAT-1] ? adr[RD_LAT-1] : '0;
      bus.iDataB <= vld[RD_LAT-1] ? b : '0;
    end
  end

endmodule

// File: doc/calcu_b.md
Name: calcu_b

Overview:
- Guided-filter stage that runs directly after the a-coefficient stage (a = var·128/(var+eps)).
- Computes the offset coefficient b = (1 − a)·mean_I per pixel, in fixed point: b = ((128 − a)·mean_I) >> 7.
- Reads a from RAM A and mean_I from RAM M, both over the full 300x400 frame, and writes b to RAM B.
- Uses the same ena/done one-shot handshake as the neighbouring compute stages.

Parameters:
- NPIX, 120000, pixels per frame (300*400); benches may override to a small value.
- AW, 17, RAM address width.
- DW, 24, RAM data width.
- FRAC, 7, fractional bits of a; 1.0 == 1<<FRAC == 128.
- RD_LAT, 1, read latency of RAM A and RAM M in cycles (synchronous RAM).

Ports:
- iCLK  in  1  clock.
- iRST_N  in  1  reset; synchronous, active-low; clock iCLK.
- ena  in  1  start request, sampled only in IDLE.
- done  out  1  one-cycle pulse when the last b has been written.
- oDataA  in  DW  RAM A read data (a, Q.FRAC).
- oDataM  in  DW  RAM M read data (mean_I, integer).
- iAddrA  out  AW  RAM A read address.
- iAddrM  out  AW  RAM M read address; always equal to iAddrA.
- wrenA  out  1  RAM A write enable; tied 0.
- wrenM  out  1  RAM M write enable; tied 0.
- iAddrB  out  AW  RAM B write address.
- wrenB  out  1  RAM B write enable.
- iDataB  out  DW  RAM B write data (b).

Behaviour:
- Reset (iRST_N low at a posedge):
  - State IDLE; rd_addr=0; write pipeline valid bits cleared.
  - All outputs 0: done, wrenB, iAddrA, iAddrM, iAddrB, iDataB.
  - Reset mid-operation aborts immediately; the partial frame is not completed and no done pulse is issued.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: if ena goes to RUN; rd_addr=0.
  - RUN:
    - Issue read address rd_addr each cycle; rd_addr increments by 1.
    - When rd_addr == NPIX-1, rd_addr returns to 0 next cycle and the FSM goes to DRAIN.
    - Exactly NPIX addresses are issued, 0..NPIX-1, with no gaps.
  - DRAIN: holds for RD_LAT+1 cycles (down-counter), then goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- ena is ignored outside IDLE. If ena is held high continuously, a new frame starts on the cycle after DONE (one IDLE cycle in between).
- Read path:
  - iAddrA = iAddrM = rd_addr while in RUN; 0 otherwise.
  - A read issued at cycle t returns oDataA/oDataM at cycle t+RD_LAT.
- Compute:
  - a_c = min(oDataA, 128); values above 128 clamp to 128.
  - prod = (128 − a_c) · oDataM, computed unsigned at ≥ DW+FRAC+1 bits with no truncation before the shift.
  - b = prod >> FRAC, truncated (floor, no rounding).
  - b ≤ mean_I always, so b fits in DW bits.
  - b is registered in one pipeline stage.
- Write path:
  - A valid/address shift register of depth RD_LAT+1 tracks each issued read.
  - Pixel k, read at cycle t, is written at cycle t+RD_LAT+1: wrenB=1, iAddrB=k, iDataB=b(k).
  - wrenB is high for exactly NPIX cycles per frame, on consecutive cycles, in ascending address order.
  - When wrenB=0: iAddrB=0 and iDataB=0.
- Timing:
  - The last write (address NPIX-1) occurs on the final DRAIN cycle.
  - done is asserted on the cycle after that last write.
  - Total from the ena-sampled edge to done high: NPIX + RD_LAT + 2 cycles.
- No back-pressure: RAM B accepts one write per cycle.

Test Plan:
- NPIX=16, RD_LAT=1, a[k]=0, m[k]=200 → every B[k]=200; wrenB high 16 consecutive cycles; done pulse 1 cycle, 19 cycles after ena edge.
- a=64, m=100 → b=50; a=127, m=255 → b=1; a=128, m=255 → b=0; a=1, m=255 → b=253.
- a=300 (above 1.0), m=90 → clamped, b=0.
- Addressing check: iAddrB sequence 0..15 strictly ascending with no repeats; iAddrB lags iAddrA by exactly RD_LAT+1; wrenA=wrenM=0 throughout.
- Reset asserted at RUN address 7 → next cycle wrenB=0, done=0, all addresses 0, FSM in IDLE; a fresh ena restarts at address 0 and completes normally.
- ena held high for 3 frames → three done pulses with period NPIX+RD_LAT+3 cycles; ena pulse during RUN/DRAIN has no effect.
